ps2_device_link: RTL

- Device-side (keyboard-end) PS/2 link layer: generates PS/2 clock, transmits bytes device→host, receives host→device commands with ack.
- Counterpart to the host protocol block; used for keyboard emulation and for closed-loop benches.
- Connects to two open-drain pin wrappers (in/out/oe) and to ready/valid byte streams.

---
 rtl/ps2_device_pkg.sv | 27 ++
 rtl/ps2_device_half_bit_timer.sv | 38 +++
 rtl/ps2_device_link.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_device_pkg.sv
// Shared types and frame constants for the
// device-side PS/2 link layer.
package ps2_device_pkg;

  typedef enum logic [2:0] {
    ST_HOLDOFF,
    ST_IDLE,
    ST_TX_HIGH,
    ST_TX_LOW,
    ST_RX_LOW,
    ST_RX_HIGH
  } state_e;

  localparam int FRAME_BITS   = 11;
  localparam int RX_DATA_BITS = 8;
  localparam int PARITY_INDEX = 8;
  localparam int STOP_INDEX   = 9;
  localparam int ACK_INDEX    = 10;

  // start 0, data LSB first, odd parity, stop 1
  function automatic logic [FRAME_BITS-1:0] tx_frame(
    input logic [7:0] b
  );
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_device_half_bit_timer.sv
// Shared down-counter for half-bit phases and the
// holdoff window; flags last cycle and mid-point.
module ps2_device_half_bit_timer #(
  parameter int unsigned HALF_BIT_CYCLES = 1500,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             expire_o,
  output logic             mid_o,
  output logic             early_o
);

  localparam logic [CNT_W-1:0] MID =
    CNT_W'(HALF_BIT_CYCLES - HALF_BIT_CYCLES / 2);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o   = (cnt_q == '0);
  assign expire_o = (cnt_q == CNT_W'(1));
  assign mid_o    = (cnt_q == MID);
  assign early_o  = (cnt_q > MID);

endmodule

// File: rtl/ps2_device_link.sv
// Device-side PS/2 link: clock generation, device->host
// byte transmit with inhibit retry, host->device receive.
module ps2_device_link
  import ps2_device_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYCLES = 1500,
  parameter int unsigned IDLE_CYCLES     = 2400
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_out,
  output logic       ps2_clk_oe,
  input  logic       ps2_data_in,
  output logic       ps2_data_out,
  output logic       ps2_data_oe,
  output logic       tx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_error
);

  localparam int unsigned MAXC =
    (HALF_BIT_CYCLES > IDLE_CYCLES) ?
    HALF_BIT_CYCLES : IDLE_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] HALF_V =
    CNT_W'(HALF_BIT_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_V1 =
    CNT_W'(IDLE_CYCLES - 1);
  localparam logic [3:0] LAST4 = 4'(FRAME_BITS - 1);
  localparam logic [3:0] STOP4 = 4'(STOP_INDEX);
  localparam logic [3:0] ACK4  = 4'(ACK_INDEX);

  state_e            state_q, state_d;
  logic [3:0]        bit_q, bit_d;
  logic              held_q, held_d;
  logic [7:0]        txb_q, txb_d;
  logic [STOP_INDEX:0] sr_q, sr_d;
  logic              bad_q, bad_d;
  logic              rxv_q, rxv_d;
  logic [7:0]        rxb_q, rxb_d;
  logic              rxe_q, rxe_d;

  logic             tmr_load, tmr_dec;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero, tmr_expire;
  logic             tmr_mid, tmr_early;
  logic             clk_oe_c, data_oe_c, ready_c;
  logic             rts;
  logic [FRAME_BITS-1:0] frame;

  ps2_device_half_bit_timer #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (reset_low),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero),
    .expire_o  (tmr_expire),
    .mid_o     (tmr_mid),
    .early_o   (tmr_early)
  );

  assign rts   = ps2_clk_in & ~ps2_data_in;
  assign frame = tx_frame(txb_q);

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q <= ST_HOLDOFF;
      bit_q   <= '0;
      held_q  <= 1'b0;
      txb_q   <= '0;
      sr_q    <= '0;
      bad_q   <= 1'b0;
      rxv_q   <= 1'b0;
      rxb_q   <= '0;
      rxe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      held_q  <= held_d;
      txb_q   <= txb_d;
      sr_q    <= sr_d;
      bad_q   <= bad_d;
      rxv_q   <= rxv_d;
      rxb_q   <= rxb_d;
      rxe_q   <= rxe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    held_d    = held_q;
    txb_d     = txb_q;
    sr_d      = sr_q;
    bad_d     = bad_q;
    rxv_d     = rxv_q & ~rx_ready;
    rxb_d     = rxb_q;
    rxe_d     = rxe_q;
    tmr_load  = 1'b0;
    tmr_val   = HALF_V;
    tmr_dec   = 1'b0;
    clk_oe_c  = 1'b0;
    data_oe_c = 1'b0;
    ready_c   = 1'b0;
    unique case (state_q)
      ST_HOLDOFF: begin
        // zero count means "restart": first high cycle counts as one
        if (!(ps2_clk_in & ps2_data_in)) begin
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else if (tmr_zero) begin
          if (IDLE_CYCLES <= 1) begin
            state_d = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = IDLE_V1;
          end
        end else if (tmr_expire) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_IDLE: begin
        ready_c = ~rts & ~rxv_q & ~held_q;
        if (rts) begin
          if (!rxv_q) begin
            state_d  = ST_RX_LOW;
            bit_d    = '0;
            bad_d    = 1'b0;
            tmr_load = 1'b1;
          end
        end else if (held_q || (ready_c && tx_valid)) begin
          if (!held_q) begin
            txb_d  = tx_byte;
            held_d = 1'b1;
          end
          state_d  = ST_TX_HIGH;
          bit_d    = '0;
          tmr_load = 1'b1;
        end
      end
      ST_TX_HIGH: begin
        data_oe_c = ~frame[bit_q];
        if (!ps2_clk_in) begin
          state_d  = ST_HOLDOFF;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else if (tmr_expire) begin
          state_d  = ST_TX_LOW;
          tmr_load = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_TX_LOW: begin
        clk_oe_c  = 1'b1;
        data_oe_c = ~frame[bit_q];
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (bit_q == LAST4) begin
            state_d = ST_HOLDOFF;
            held_d  = 1'b0;
            tmr_val = '0;
          end else begin
            state_d = ST_TX_HIGH;
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RX_LOW: begin
        clk_oe_c  = 1'b1;
        data_oe_c = (bit_q == ACK4);
        if (tmr_expire) begin
          state_d  = ST_RX_HIGH;
          tmr_load = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RX_HIGH: begin
        data_oe_c = (bit_q == ACK4) & tmr_early;
        if (tmr_mid && bit_q <= STOP4) begin
          sr_d[bit_q] = ps2_data_in;
        end
        if (tmr_expire) begin
          tmr_load = 1'b1;
          state_d  = ST_RX_LOW;
          if (bit_q == ACK4) begin
            rxb_d   = sr_q[RX_DATA_BITS-1:0];
            rxe_d   = ~^sr_q[PARITY_INDEX:0];
            rxv_d   = 1'b1;
            state_d = ST_HOLDOFF;
            tmr_val = '0;
          end else if (bit_q == STOP4) begin
            // bad stop: clock on until host lets data go high
            if (!sr_q[STOP_INDEX]) begin
              bad_d = 1'b1;
            end else if (bad_q) begin
              state_d = ST_HOLDOFF;
              tmr_val = '0;
            end else begin
              bit_d = ACK4;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLDOFF;
      end
    endcase
  end

  assign ps2_clk_out  = 1'b0;
  assign ps2_data_out = 1'b0;
  assign ps2_clk_oe   = clk_oe_c;
  assign ps2_data_oe  = data_oe_c;
  assign tx_ready     = ready_c;
  assign rx_valid     = rxv_q;
  assign rx_byte      = rxb_q;
  assign rx_error     = rxe_q;

endmodule
